// File: rtl/pc_bus_ctrl.sv
// pc_bus_ctrl: 8088 system-bus controller turning the multiplexed CPU bus into
// latched address/data, MEMR/MEMW/IOR/IOW strobes, wait states and a timeout.
module pc_bus_ctrl #(
  parameter int WAIT_MEM = 0,
  parameter int WAIT_IO  = 1,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] a,
  input  logic        ale,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        iom,
  input  logic        den_n,
  input  logic        dtr,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        ready,
  output logic [19:0] sys_addr,
  output logic [7:0]  sys_wdata,
  input  logic [7:0]  sys_rdata,
  input  logic        sys_ack,
  output logic        memr_n,
  output logic        memw_n,
  output logic        ior_n,
  output logic        iow_n,
  output logic        bus_err,
  input  logic        clr_err
);
  typedef enum logic [1:0] {IDLE, ADDR, CMD, HOLD} state_t;
  state_t            state_q, state_d;
  logic [19:0]       sys_addr_q, sys_addr_d;
  logic [7:0]        sys_wdata_q, sys_wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_io_q, is_io_d, is_wr_q, is_wr_d, bus_err_q, bus_err_d;
  logic              in_cmd, active, done, tmo, bus_idle;
  always_comb begin
    in_cmd      = state_q == CMD;
    active      = in_cmd || state_q == HOLD;
    bus_idle    = rd_n && wr_n;
    done        = in_cmd && sys_ack &&
                  (cnt_q >= (is_io_q ? CNT_W'(WAIT_IO) : CNT_W'(WAIT_MEM)));
    tmo         = in_cmd && !done && cnt_q == CNT_W'(TIMEOUT);
    state_d     = state_q;
    sys_addr_d  = sys_addr_q;
    sys_wdata_d = sys_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    is_io_d     = is_io_q;
    is_wr_d     = is_wr_q;
    bus_err_d   = bus_err_q && !clr_err;
    if (ale) begin
      state_d    = ADDR;
      sys_addr_d = a;
      is_io_d    = iom;
      cnt_d      = '0;
      if (in_cmd) bus_err_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          cnt_d = '0;
          if (!rd_n) begin
            state_d = CMD;
            is_wr_d = 1'b0;
          end else if (!wr_n) begin
            state_d     = CMD;
            is_wr_d     = 1'b1;
            sys_wdata_d = ad_in;
          end
        end
        CMD: begin
          cnt_d = cnt_q + 1'b1;
          if (done) begin
            state_d = HOLD;
            if (!is_wr_q) rdata_d = sys_rdata;
          end else if (tmo) begin
            state_d   = HOLD;
            rdata_d   = 8'hFF;
            bus_err_d = 1'b1;
          end else if (bus_idle) begin
            state_d   = IDLE;
            bus_err_d = 1'b1;
          end
        end
        HOLD: state_d = bus_idle ? IDLE : HOLD;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sys_addr_q  <= '0;
      sys_wdata_q <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      is_io_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sys_addr_q  <= sys_addr_d;
      sys_wdata_q <= sys_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      is_io_q     <= is_io_d;
      is_wr_q     <= is_wr_d;
      bus_err_q   <= bus_err_d;
    end
  end
  // Strobes decode straight from registered state, so reset releases them at once.
  assign memr_n    = !(active && !is_io_q && !is_wr_q);
  assign memw_n    = !(active && !is_io_q &&  is_wr_q);
  assign ior_n     = !(active &&  is_io_q && !is_wr_q);
  assign iow_n     = !(active &&  is_io_q &&  is_wr_q);
  assign ready     = !(in_cmd && !done);
  assign ad_oe     = active && !is_wr_q && !rd_n && !den_n && !dtr;
  assign ad_out    = in_cmd ? sys_rdata : (state_q == HOLD ? rdata_q : 8'h00);
  assign sys_addr  = sys_addr_q;
  assign sys_wdata = sys_wdata_q;
  assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_pc_bus_ctrl.sv
// tb_pc_bus_ctrl: transaction-level scoreboard bench for pc_bus_ctrl.
module tb_pc_bus_ctrl;
  localparam int WAIT_MEM = 0;
  localparam int WAIT_IO  = 1;
  localparam int TIMEOUT  = 15;
  localparam int CNT_W    = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] a;
  logic        ale, rd_n, wr_n, iom, den_n, dtr, sys_ack, clr_err;
  logic [7:0]  ad_in, sys_rdata, ad_out, sys_wdata;
  logic        ad_oe, ready, memr_n, memw_n, ior_n, iow_n, bus_err;
  logic [19:0] sys_addr;

  pc_bus_ctrl #(.WAIT_MEM(WAIT_MEM), .WAIT_IO(WAIT_IO), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .a(a), .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .iom(iom),
    .den_n(den_n), .dtr(dtr), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .ready(ready), .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_rdata(sys_rdata),
    .sys_ack(sys_ack), .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n),
    .bus_err(bus_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [19:0] addr;
    logic [7:0]  wdata;
    int          wt;
    logic [7:0]  last_ad;
    logic        oe;
    logic        err;
    logic [19:0] addr_after;
    int          multi;
  } rec_t;

  rec_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  bit         mon_en = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; den_n = 1'b1; dtr = 1'b0; sys_ack = 1'b0;
  endtask

  // kind: 0 = normal cycle, 1 = strobes released early, 2 = ale during CMD
  task automatic txn(input bit io, input bit wr, input bit both, input logic [19:0] addr,
                     input logic [7:0] wd, input logic [7:0] rdv, input int ackd,
                     input int hold_len, input int kind, input logic [19:0] naddr);
    int w, c, r, kd;
    bit timed;
    rec_t e;
    w  = io ? WAIT_IO : WAIT_MEM;
    c  = ackd > w ? ackd : w;
    timed = c > TIMEOUT;
    if (timed) c = TIMEOUT;
    kd = c == 0 ? 0 : kind;
    r  = kd != 0 ? int'($urandom_range(c - 1, 0)) : 0;
    e.mask  = io ? (wr ? 4'b0001 : 4'b0010) : (wr ? 4'b0100 : 4'b1000);
    e.addr  = addr;
    if (wr) m_wdata = wd;
    e.wdata = m_wdata;
    e.multi = 0;
    if (kd == 0) begin
      if (timed) m_rdata = 8'hFF;
      else if (!wr) m_rdata = rdv;
      e.last_ad    = m_rdata;
      e.wt         = timed ? TIMEOUT + 1 : c;
      e.oe         = !wr;
      e.err        = timed;
      e.addr_after = addr;
    end else begin
      e.last_ad    = rdv;
      e.wt         = r + 1;
      e.oe         = !wr && r > 0;
      e.err        = 1'b1;
      e.addr_after = kd == 2 ? naddr : addr;
    end
    exp_q.push_back(e);
    ale = 1'b1; a = addr; iom = io; rd_n = 1'b1; wr_n = 1'b1; sys_rdata = rdv;
    step;
    ale = 1'b0; rd_n = wr; wr_n = wr ? 1'b0 : !both; ad_in = wd; den_n = 1'b0; dtr = wr;
    step;
    for (int k = 0; k <= c; k++) begin
      sys_ack = k >= ackd;
      if (kd != 0 && k == r) begin
        rd_n = 1'b1; wr_n = 1'b1;
        if (kd == 2) begin
          ale = 1'b1; a = naddr; iom = 1'($urandom_range(0, 1));
        end
        step;
        break;
      end
      step;
    end
    if (kd == 0) begin
      repeat (hold_len) step;
      rd_n = 1'b1; wr_n = 1'b1;
      step;
    end
    idle_in;
    step;
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("err_clr", 32'(bus_err), 0);
  endtask

  // Monitor: assembles one record per strobe-low interval and scores it.
  initial begin
    rec_t cur, e;
    bit in_t;
    logic [3:0] low;
    in_t = 1'b0;
    forever begin
      @(negedge clk);
      low = {!memr_n, !memw_n, !ior_n, !iow_n};
      if (!mon_en) in_t = 1'b0;
      else if (low != 4'b0000) begin
        if (!in_t) begin
          in_t = 1'b1; cur.mask = low; cur.addr = sys_addr; cur.wdata = sys_wdata;
          cur.wt = 0; cur.oe = 1'b0; cur.multi = 0;
        end
        if ($countones(low) > 1) cur.multi++;
        if (!ready) cur.wt++;
        cur.oe = cur.oe | ad_oe;
        cur.last_ad = ad_out;
      end else if (in_t) begin
        in_t = 1'b0;
        cur.err = bus_err;
        cur.addr_after = sys_addr;
        if (exp_q.size() == 0) chk("unexpected_txn", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("strobe", 32'(cur.mask), 32'(e.mask));
          chk("addr", 32'(cur.addr), 32'(e.addr));
          chk("wdata", 32'(cur.wdata), 32'(e.wdata));
          chk("wait_cycles", cur.wt, e.wt);
          chk("ad_out", 32'(cur.last_ad), 32'(e.last_ad));
          chk("ad_oe", 32'(cur.oe), 32'(e.oe));
          chk("bus_err", 32'(cur.err), 32'(e.err));
          chk("addr_after", 32'(cur.addr_after), 32'(e.addr_after));
          chk("multi_strobe", cur.multi, e.multi);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_in;
    a = '0; iom = 1'b0; ad_in = '0; sys_rdata = '0; clr_err = 1'b0; rst = 1'b0;
    #12;
    chk("rst_strobes", 32'({memr_n, memw_n, ior_n, iow_n}), 32'hF);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_ad_oe", 32'(ad_oe), 0);
    chk("rst_ad_out", 32'(ad_out), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_sys_addr", 32'(sys_addr), 0);
    chk("rst_sys_wdata", 32'(sys_wdata), 0);
    step;
    rst = 1'b1;
    mon_en = 1'b1;
    step;
    txn(1'b0, 1'b0, 1'b0, 20'hFFFF0, 8'h00, 8'hEA, 0, 1, 0, 20'h0);
    txn(1'b1, 1'b1, 1'b0, 20'h00061, 8'h4C, 8'h00, 0, 1, 0, 20'h0);
    txn(1'b0, 1'b0, 1'b0, 20'h12345, 8'h00, 8'h5A, 3, 0, 0, 20'h0);
    txn(1'b0, 1'b0, 1'b0, 20'hABCDE, 8'h00, 8'h11, 100, 2, 0, 20'h0);
    txn(1'b1, 1'b1, 1'b0, 20'h00300, 8'h99, 8'h00, 100, 0, 0, 20'h0);
    txn(1'b0, 1'b0, 1'b0, 20'h22222, 8'h00, 8'h33, 5, 0, 1, 20'h0);
    txn(1'b0, 1'b1, 1'b0, 20'h33333, 8'h77, 8'h44, 5, 0, 2, 20'h44444);
    txn(1'b0, 1'b0, 1'b1, 20'h0BEEF, 8'hC3, 8'h6D, 1, 0, 0, 20'h0);
    mon_en = 1'b0;
    ale = 1'b1; a = 20'h55555; iom = 1'b0;
    step;
    ale = 1'b0; rd_n = 1'b0; den_n = 1'b0; sys_ack = 1'b0;
    step;
    step;
    chk("pre_rst_memr", 32'(memr_n), 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_strobes", 32'({memr_n, memw_n, ior_n, iow_n}), 32'hF);
    chk("async_rst_ready", 32'(ready), 1);
    chk("async_rst_ad_oe", 32'(ad_oe), 0);
    chk("async_rst_addr", 32'(sys_addr), 0);
    idle_in;
    step;
    rst = 1'b1;
    m_rdata = 8'h00;
    m_wdata = 8'h00;
    mon_en = 1'b1;
    step;
    for (int i = 0; i < 120; i++) begin
      int sel;
      sel = int'($urandom_range(0, 5));
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          20'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(0, 7) == 0 ? 100 : int'($urandom_range(0, 6)),
          int'($urandom_range(0, 2)), sel < 4 ? 0 : sel - 3, 20'($urandom));
    end
    step;
    step;
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
